// File: rtl/seq_addsub_pipe.sv
// seq_addsub_pipe
//   Multi-cycle adder/subtractor. Processes CHUNK bits per clock and carries
//   the chunk carry forward in a register, so each cycle has a CHUNK-bit
//   carry chain instead of a WIDTH-bit one. NCHUNK = WIDTH/CHUNK run cycles
//   per operation. WIDTH must be a multiple of CHUNK.
//
//   Handshake (both sides): a transfer happens on a rising edge where
//   valid and ready are both high. in_ready is high only in IDLE and
//   out_valid only in DONE, both decoded from registered state. in_valid
//   outside IDLE and out_ready outside DONE are ignored.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   in_valid     operands a, b, cin, sub are valid (sampled at accept only)
//   in_ready     block is IDLE and can accept an operation
//   a, b         WIDTH-bit operands
//   cin          carry-in (borrow-in when sub=1)
//   sub          0: a+b+cin, 1: a-b-cin
//   out_valid    result valid (DONE)
//   out_ready    consumer takes the result
//   sum          result modulo 2^WIDTH
//   cout         carry out of the MSB (for sub=1, 1 means no borrow)
//   ovf          two's-complement overflow
//   busy         state is not IDLE
//   state_dbg    current FSM state (0 IDLE, 1 RUN, 2 DONE) for checkers
module seq_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_nxt;
  logic             last;
  logic             msb_cin;

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- state-decoded outputs ----------------
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    state_dbg = state;
  end

  // ---------------- chunk datapath ----------------
  // Operand registers shift right by CHUNK each run cycle, so the chunk
  // being processed is always the low CHUNK bits; this is the same chunk
  // that cnt indexes. Result chunks enter at the top of res_r and move
  // down, landing in place after NCHUNK cycles.
  always_comb begin
    chunk_sum = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry};
    res_nxt   = (res_r >> CHUNK)
              | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    last      = (cnt == CW'(NCHUNK - 1));
    // On the last chunk the top operand bits are the word MSBs; the carry
    // into the MSB is recovered from its sum bit: s = a ^ b ^ c_in.
    msb_cin   = a_r[CHUNK-1] ^ b_r[CHUNK-1] ^ chunk_sum[CHUNK-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            // a - b - cin == a + ~b + ~cin
            carry <= cin ^ sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_r   <= a_r >> CHUNK;
          b_r   <= b_r >> CHUNK;
          res_r <= res_nxt;
          carry <= chunk_sum[CHUNK];
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum  <= res_nxt;
            cout <= chunk_sum[CHUNK];
            ovf  <= msb_cin ^ chunk_sum[CHUNK];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub_pipe.sv
// Directed bench for seq_addsub_pipe: a 32/8 instance for latency, ripple,
// subtract, overflow, backpressure and reset-abort cases, and a 4/4
// instance swept against a plain a+b+cin reference.
module tb_seq_addsub_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 32-bit, 8-bit chunk instance
  logic        in_valid, in_ready, out_valid, out_ready, cin, sub, cout, ovf, busy;
  logic [31:0] a, b, sum;
  logic [1:0]  state_dbg;

  // 4-bit single-chunk instance
  logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, sub4, cout4, ovf4, busy4;
  logic [3:0]  a4, b4, sum4;
  logic [1:0]  state_dbg4;

  seq_addsub_pipe #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .state_dbg(state_dbg)
  );

  seq_addsub_pipe #(.WIDTH(4), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4), .state_dbg(state_dbg4)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // One full 32-bit operation: accept, wait for out_valid, check, retire.
  task automatic op32(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                      input logic tcin, input logic tsub,
                      input logic [31:0] e_sum, input logic e_cout, input logic e_ovf);
    int lat;
    @(negedge clk);
    check({tag, "_inrdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = ta; b = tb; cin = tcin; sub = tsub;
    @(negedge clk);
    // operands change right after accept; result must not follow them
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = ~tcin; sub = ~tsub;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd4);
    check({tag, "_sum"}, 64'(sum), 64'(e_sum));
    check({tag, "_cout"}, 64'(cout), 64'(e_cout));
    check({tag, "_ovf"}, 64'(ovf), 64'(e_ovf));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle"}, 64'(in_ready), 64'd1);
  endtask

  task automatic op4(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                     input logic tcin,
                     input logic [3:0] e_sum, input logic e_cout, input logic e_ovf);
    int lat;
    @(negedge clk);
    in_valid4 = 1'b1; a4 = ta; b4 = tb; cin4 = tcin; sub4 = 1'b0;
    @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd1);
    check({tag, "_sum"}, 64'(sum4), 64'(e_sum));
    check({tag, "_cout"}, 64'(cout4), 64'(e_cout));
    check({tag, "_ovf"}, 64'(ovf4), 64'(e_ovf));
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [4:0]  ref5;
    logic [31:0] held_sum;
    logic        held_cout, held_ovf;
    int          lat;

    in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0; sub = 0;
    in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_inrdy", 64'(in_ready), 64'd1);
    check("rst_oval", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_inrdy4", 64'(in_ready4), 64'd1);

    // 4-bit: 9+7+1 = 17 -> sum 1, cout 1; carry into MSB 1, so ovf 0
    op4("w4_9_7_1", 4'd9, 4'd7, 1'b1, 4'd1, 1'b1, 1'b0);

    // 4-bit exhaustive sweep against a+b+cin
    for (int i = 0; i < 512; i++) begin
      logic [3:0] sa, sb;
      logic       sc, e_ovf;
      sa = i[3:0]; sb = i[7:4]; sc = i[8];
      ref5 = {1'b0, sa} + {1'b0, sb} + {4'd0, sc};
      e_ovf = (sa[3] == sb[3]) && (ref5[3] != sa[3]);
      op4("w4_sweep", sa, sb, sc, ref5[3:0], ref5[4], e_ovf);
    end

    // carry ripples through all four chunks
    op32("ripple", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    op32("chunk_edge", 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    op32("add_cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0);

    // subtraction
    op32("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    op32("sub_7_5_b", 32'd7, 32'd5, 1'b1, 1'b1, 32'h1, 1'b1, 1'b0);

    // signed overflow
    op32("ovf_add", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    op32("ovf_sub", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // backpressure and ignored inputs: 0x12345678 + 0x11111111 = 0x23456789
    @(negedge clk);
    in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = ~in_valid;
      a = $urandom;
      @(negedge clk);
      lat++;
    end
    check("bp_lat", 64'(lat), 64'd4);
    held_sum = sum; held_cout = cout; held_ovf = ovf;
    check("bp_sum", 64'(held_sum), 64'h2345_6789);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a = $urandom;
      @(negedge clk);
      check("bp_hold_sum", 64'(sum), 64'(held_sum));
      check("bp_hold_cout", 64'(cout), 64'(held_cout));
      check("bp_hold_ovf", 64'(ovf), 64'(held_ovf));
      check("bp_inrdy", 64'(in_ready), 64'd0);
      check("bp_oval", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_rel_inrdy", 64'(in_ready), 64'd1);
    check("bp_rel_oval", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("bp_no_extra", 64'(busy), 64'd0);
    check("bp_sum_kept", 64'(sum), 64'h2345_6789);

    // reset in the middle of RUN (cnt=2)
    @(negedge clk);
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_oval", 64'(out_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    check("abort_inrdy", 64'(in_ready), 64'd1);
    op32("after_abort", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h7, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
